// File: rtl/usb_pio_pkg.sv
// Shared definitions for the USB PIO input port.
//   ADDR_*        : word addresses of the four slave registers
//   MAX_WIDTH     : width of the Avalon data bus (widest legal port)
//   WARMUP_CYCLES : cycles after reset release before edges may be captured
package usb_pio_pkg;

  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_MASK = 2'd1;
  localparam logic [1:0] ADDR_EDGE = 2'd2;
  localparam logic [1:0] ADDR_POL  = 2'd3;

  localparam int MAX_WIDTH     = 32;
  localparam int WARMUP_CYCLES = 3;

endpackage

// File: rtl/usb_pio_in_sync.sv
// Input conditioning for the USB PIO input port: 2-flop synchronizer,
// optional per-bit debounce filter, and the previous-value register used
// for edge detection.
//   clk, reset_n : clock, asynchronous active-low reset
//   in_port      : raw asynchronous lines
//   filt         : synchronized (and, if enabled, debounced) value
//   rise, fall   : per-bit edges of filt relative to its previous value
// Build option: USB_PIO_IN_DEBOUNCE_EN adds an 8-bit stability counter per
// bit; filt only follows sync2 after DEBOUNCE_CYCLES stable cycles.
module usb_pio_in_sync
  import usb_pio_pkg::*;
#(
  parameter int DATA_WIDTH      = 8,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [DATA_WIDTH-1:0] in_port,
  output logic [DATA_WIDTH-1:0] filt,
  output logic [DATA_WIDTH-1:0] rise,
  output logic [DATA_WIDTH-1:0] fall
);

  logic [DATA_WIDTH-1:0] sync1;
  logic [DATA_WIDTH-1:0] sync2;
  logic [DATA_WIDTH-1:0] prev;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= in_port;
      sync2 <= sync1;
    end
  end

`ifdef USB_PIO_IN_DEBOUNCE_EN
  logic [DATA_WIDTH-1:0] filt_q;
  logic [7:0]            db_cnt [DATA_WIDTH];

  // Any disagreement between sync2 and filt must persist for
  // DEBOUNCE_CYCLES consecutive cycles before filt follows; a return to
  // agreement restarts the count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      filt_q <= '0;
      for (int i = 0; i < DATA_WIDTH; i++) db_cnt[i] <= 8'd0;
    end else begin
      for (int i = 0; i < DATA_WIDTH; i++) begin
        if (sync2[i] == filt_q[i]) begin
          db_cnt[i] <= 8'd0;
        end else if (db_cnt[i] == 8'(DEBOUNCE_CYCLES - 1)) begin
          filt_q[i] <= sync2[i];
          db_cnt[i] <= 8'd0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 8'd1;
        end
      end
    end
  end

  assign filt = filt_q;
`else
  assign filt = sync2;
`endif

  // prev tracks filt so edges are always taken on the conditioned value.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) prev <= '0;
    else          prev <= filt;
  end

  assign rise = filt & ~prev;
  assign fall = ~filt & prev;

endmodule

// File: rtl/usb_pio_in.sv
// Avalon-MM slave input port for the USB controller status lines.
// Registers: 0 DATA (RO), 1 MASK (RW), 2 EDGE (W1C capture), 3 POL (RW,
// 1 = rising, 0 = falling). Reads are zero-wait and combinational from
// address. irq is the OR of captured edges that are masked in.
//   clk, reset_n          : clock, asynchronous active-low reset
//   address, chipselect   : 2-bit word address, slave select
//   write_n, writedata    : active-low write strobe, 32-bit write data
//   in_port               : asynchronous lines from the USB controller
//   readdata, irq         : read data (zero-extended), interrupt request
// Build option: USB_PIO_IN_DEBOUNCE_EN enables the input debounce filter
// and lengthens the post-reset warm-up accordingly.
module usb_pio_in
  import usb_pio_pkg::*;
#(
  parameter int DATA_WIDTH      = 8,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [1:0]            address,
  input  logic                  chipselect,
  input  logic                  write_n,
  input  logic [31:0]           writedata,
  input  logic [DATA_WIDTH-1:0] in_port,
  output logic [31:0]           readdata,
  output logic                  irq
);

  if (DATA_WIDTH < 1 || DATA_WIDTH > MAX_WIDTH) begin : g_bad_width
    $error("usb_pio_in: DATA_WIDTH out of range");
  end
  if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > 255) begin : g_bad_debounce
    $error("usb_pio_in: DEBOUNCE_CYCLES out of range");
  end

`ifdef USB_PIO_IN_DEBOUNCE_EN
  localparam int WARMUP_TOTAL = WARMUP_CYCLES + DEBOUNCE_CYCLES;
`else
  localparam int WARMUP_TOTAL = WARMUP_CYCLES;
`endif

  logic [DATA_WIDTH-1:0] filt;
  logic [DATA_WIDTH-1:0] rise;
  logic [DATA_WIDTH-1:0] fall;
  logic [DATA_WIDTH-1:0] mask_q;
  logic [DATA_WIDTH-1:0] edge_q;
  logic [DATA_WIDTH-1:0] pol_q;
  logic [DATA_WIDTH-1:0] wdata;
  logic [DATA_WIDTH-1:0] edge_set;
  logic [DATA_WIDTH-1:0] edge_clr;
  logic [8:0]            warm_cnt;
  logic                  warm_done;
  logic                  wr;

  usb_pio_in_sync #(
    .DATA_WIDTH      (DATA_WIDTH),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .in_port (in_port),
    .filt    (filt),
    .rise    (rise),
    .fall    (fall)
  );

  if (DATA_WIDTH < MAX_WIDTH) begin : g_hi_bits
    logic unused_writedata_hi;
    assign unused_writedata_hi = ^writedata[MAX_WIDTH-1:DATA_WIDTH];
  end

  assign wr    = chipselect && !write_n;
  assign wdata = writedata[DATA_WIDTH-1:0];

  // Edges are ignored until the synchronizer (and filter) have flushed the
  // reset zeros, otherwise lines high at reset would look like rises.
  assign warm_done = (warm_cnt == 9'(WARMUP_TOTAL));
  assign edge_set  = warm_done ? ((pol_q & rise) | (~pol_q & fall)) : '0;
  assign edge_clr  = (wr && address == ADDR_EDGE) ? wdata : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) warm_cnt <= 9'd0;
    else if (!warm_done) warm_cnt <= warm_cnt + 9'd1;
  end

  // Set is applied after clear so a coincident capture survives.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mask_q <= '0;
      pol_q  <= '0;
      edge_q <= '0;
    end else begin
      if (wr && address == ADDR_MASK) mask_q <= wdata;
      if (wr && address == ADDR_POL)  pol_q  <= wdata;
      edge_q <= (edge_q & ~edge_clr) | edge_set;
    end
  end

  assign irq = |(edge_q & mask_q);

  always_comb begin
    readdata = '0;
    case (address)
      ADDR_DATA: readdata[DATA_WIDTH-1:0] = filt;
      ADDR_MASK: readdata[DATA_WIDTH-1:0] = mask_q;
      ADDR_EDGE: readdata[DATA_WIDTH-1:0] = edge_q;
      default:   readdata[DATA_WIDTH-1:0] = pol_q;
    endcase
  end

endmodule

// File: tb/tb_usb_pio_in.sv
// Bench for usb_pio_in (DATA_WIDTH = 8, DEBOUNCE_CYCLES = 4).
// The reference model keeps the history of in_port values sampled at each
// clock edge since reset: DATA is the value sampled one edge before the
// latest, edges compare the two previous samples, and capture is allowed
// once three edges have passed since reset release.
module tb_usb_pio_in;

  logic        clk;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [7:0]  in_port;
  logic [31:0] readdata;
  logic        irq;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] m_mask;
  logic [7:0] m_pol;
  logic [7:0] m_edge;
  logic [7:0] hist[$];

  usb_pio_in #(
    .DATA_WIDTH      (8),
    .DEBOUNCE_CYCLES (4)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .in_port    (in_port),
    .readdata   (readdata),
    .irq        (irq)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // model: one clock edge with the given bus activity and line sample
  task automatic model_step(input logic [1:0] a, input logic w, input logic [31:0] wd,
                            input logic [7:0] inv);
    int k;
    logic [7:0] cur, old, sets, clr;
    k    = hist.size();
    cur  = (k >= 2) ? hist[k-2] : 8'h00;
    old  = (k >= 3) ? hist[k-3] : 8'h00;
    sets = (k >= 3) ? ((m_pol & cur & ~old) | (~m_pol & ~cur & old)) : 8'h00;
    clr  = (w && a == 2'd2) ? wd[7:0] : 8'h00;
    m_edge = (m_edge & ~clr) | sets;
    if (w && a == 2'd1) m_mask = wd[7:0];
    if (w && a == 2'd3) m_pol  = wd[7:0];
    hist.push_back(inv);
  endtask

  function automatic logic [31:0] model_rd(input logic [1:0] a);
    logic [7:0] d;
    d = (hist.size() >= 2) ? hist[hist.size()-2] : 8'h00;
    case (a)
      2'd0:    return {24'h0, d};
      2'd1:    return {24'h0, m_mask};
      2'd2:    return {24'h0, m_edge};
      default: return {24'h0, m_pol};
    endcase
  endfunction

  // driver: one bus cycle, checked against the model after the edge
  task automatic tick(input logic [1:0] a, input logic w, input logic [31:0] wd,
                      input logic [7:0] inv, input logic chk);
    @(negedge clk);
    address = a; chipselect = w; write_n = !w; writedata = wd; in_port = inv;
    @(posedge clk);
    model_step(a, w, wd, inv);
    #2;
    if (chk) begin
      check("rd", readdata, model_rd(a));
      check("irq", {31'b0, irq}, {31'b0, |(m_edge & m_mask)});
    end
  endtask

  task automatic do_reset(input logic [7:0] inv);
    @(negedge clk);
    reset_n = 1'b0; chipselect = 1'b0; write_n = 1'b1; in_port = inv; address = 2'd2;
    #1;
    check("rst_edge_now", readdata, 32'h0);
    check("rst_irq_now", {31'b0, irq}, 32'h0);
    for (int a = 0; a < 4; a++) begin
      address = a[1:0];
      #1;
      check("rst_reg", readdata, 32'h0);
    end
    m_mask = 8'h00; m_pol = 8'h00; m_edge = 8'h00;
    hist.delete();
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    model_step(address, 1'b0, 32'h0, inv);
  endtask

  task automatic run_main();
    logic [7:0]  cur_in;
    logic [1:0]  a;
    logic        w;
    // 1: lines high through reset, no spurious capture
    do_reset(8'hFF);
    for (int i = 0; i < 10; i++) tick(2'd2, 1'b0, 32'h0, 8'hFF, 1'b1);
    check("t1_edge", readdata, 32'h0);
    check("t1_irq", {31'b0, irq}, 32'h0);
    tick(2'd0, 1'b0, 32'h0, 8'hFF, 1'b1);
    check("t1_data", readdata, 32'h0000_00FF);
    // 2: rising edge on bit 0, then W1C
    tick(2'd3, 1'b1, 32'h1, 8'hFF, 1'b1);
    tick(2'd1, 1'b1, 32'h1, 8'hFF, 1'b1);
    for (int i = 0; i < 4; i++) tick(2'd2, 1'b0, 32'h0, 8'hFE, 1'b1);
    tick(2'd2, 1'b0, 32'h0, 8'hFF, 1'b1);
    check("t2_e0", readdata, 32'h0);
    tick(2'd2, 1'b0, 32'h0, 8'hFF, 1'b1);
    check("t2_e1", readdata, 32'h0);
    tick(2'd2, 1'b0, 32'h0, 8'hFF, 1'b1);
    check("t2_e2", readdata, 32'h1);
    check("t2_irq", {31'b0, irq}, 32'h1);
    tick(2'd2, 1'b1, 32'h1, 8'hFF, 1'b1);
    check("t2_clr", readdata, 32'h0);
    check("t2_irq_clr", {31'b0, irq}, 32'h0);
    // 3: falling edge on bit 3 captured while masked out
    tick(2'd3, 1'b1, 32'h0, 8'hFF, 1'b1);
    tick(2'd1, 1'b1, 32'h0, 8'hFF, 1'b1);
    for (int i = 0; i < 4; i++) tick(2'd2, 1'b0, 32'h0, 8'hF7, 1'b1);
    check("t3_edge", readdata, 32'h08);
    check("t3_irq0", {31'b0, irq}, 32'h0);
    tick(2'd1, 1'b1, 32'h08, 8'hF7, 1'b1);
    check("t3_irq1", {31'b0, irq}, 32'h1);
    tick(2'd2, 1'b1, 32'hFFFF_FFFF, 8'hF7, 1'b1);
    // 4: capture of bit 5 coincides with W1C of bits 0 and 5
    for (int i = 0; i < 4; i++) tick(2'd2, 1'b0, 32'h0, 8'hF4, 1'b1);
    check("t4_pre", readdata, 32'h03);
    tick(2'd2, 1'b0, 32'h0, 8'hD4, 1'b1);
    tick(2'd2, 1'b0, 32'h0, 8'hD4, 1'b1);
    tick(2'd2, 1'b1, 32'h21, 8'hD4, 1'b1);
    check("t4_setwins", readdata, 32'h22);
    // 5: reset in the middle of a pending capture
    for (int i = 0; i < 4; i++) tick(2'd2, 1'b0, 32'h0, 8'hFF, 1'b1);
    tick(2'd2, 1'b1, 32'hFF, 8'hFF, 1'b1);
    tick(2'd1, 1'b1, 32'hFF, 8'hFF, 1'b1);
    for (int i = 0; i < 4; i++) tick(2'd2, 1'b0, 32'h0, 8'h5A, 1'b1);
    check("t5_edge", readdata, 32'hA5);
    check("t5_irq", {31'b0, irq}, 32'h1);
    do_reset(8'hFF);
    tick(2'd3, 1'b1, 32'hFF, 8'hFF, 1'b1);
    for (int i = 0; i < 10; i++) tick(2'd2, 1'b0, 32'h0, 8'hFF, 1'b1);
    check("t5_warmup", readdata, 32'h0);
    // random traffic against the model, with one reset in the middle
    cur_in = 8'hFF;
    for (int i = 0; i < 600; i++) begin
      if (i == 300) do_reset(cur_in);
      if ($urandom_range(0, 4) == 0) cur_in = 8'($urandom);
      a = 2'($urandom_range(0, 3));
      w = ($urandom_range(0, 3) == 0);
      tick(a, w, $urandom, cur_in, 1'b1);
    end
  endtask

  task automatic run_debounce();
    do_reset(8'h00);
    for (int i = 0; i < 15; i++) tick(2'd0, 1'b0, 32'h0, 8'h00, 1'b0);
    // 2-cycle glitch on bit 1 is filtered out
    tick(2'd0, 1'b0, 32'h0, 8'h02, 1'b0);
    tick(2'd0, 1'b0, 32'h0, 8'h02, 1'b0);
    for (int i = 0; i < 12; i++) begin
      tick(2'd0, 1'b0, 32'h0, 8'h00, 1'b0);
      check("db_glitch_data", readdata, 32'h0);
    end
    tick(2'd3, 1'b1, 32'h02, 8'h00, 1'b0);
    tick(2'd2, 1'b0, 32'h0, 8'h00, 1'b0);
    check("db_glitch_edge", readdata, 32'h0);
    // stable rise: DATA follows four cycles after sync2 changes
    for (int i = 0; i < 6; i++) begin
      tick(2'd0, 1'b0, 32'h0, 8'h02, 1'b0);
      check("db_rise_data", readdata, (i < 5) ? 32'h0 : 32'h2);
    end
    tick(2'd2, 1'b0, 32'h0, 8'h02, 1'b0);
    check("db_rise_edge", readdata, 32'h2);
  endtask

  initial begin
    reset_n = 1'b0; address = 2'd0; chipselect = 1'b0; write_n = 1'b1;
    writedata = 32'h0; in_port = 8'h00;
    m_mask = 8'h00; m_pol = 8'h00; m_edge = 8'h00;
`ifdef USB_PIO_IN_DEBOUNCE_EN
    run_debounce();
`else
    run_main();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
